// File: rtl/cache_module.sv
// Set-associative L2 cache directory: tag + MESI state per line, per-set
// round-robin replacement pointer. One command per cycle, registered response.
module cache_module #(
  parameter int INDEX_W  = 4,
  parameter int TAG_W    = 12,
  parameter int WAYS     = 8,
  parameter int OFFSET_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [1:0]         op,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic [2:0]         way,
  input  logic [1:0]         mesi_cmd,
  input  logic [1:0]         snoop_result,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [2:0]         rsp_way,
  output logic [1:0]         rsp_mesi,
  output logic [3:0]         result
);

  localparam int SETS  = 2 ** INDEX_W;
  localparam int WAY_W = 3;

  typedef enum logic [1:0] {MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11} mesi_t;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_WRITE = 2'b01, OP_SET_MESI = 2'b10, OP_CHECK = 2'b11} op_t;
  typedef enum logic [1:0] {EV_CPU_RD = 2'b00, EV_CPU_WR = 2'b01, EV_SNP_RD = 2'b10, EV_SNP_RFO = 2'b11} ev_t;

  // Line offset is carried for documentation of the address split only.
  logic [OFFSET_W-1:0] unused_offset;
  assign unused_offset = '0;

  logic [TAG_W-1:0] tags   [SETS][WAYS];
  mesi_t            states [SETS][WAYS];
  logic [WAY_W-1:0] ptr    [SETS];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             free_found;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] victim;
  mesi_t            cur_state;
  mesi_t            nxt_state;
  logic [WAY_W-1:0] ptr_next;

  // Tag match (lowest valid way wins) and victim choice (lowest I way, else pointer).
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && states[index][w[WAY_W-1:0]] != MESI_I && tags[index][w[WAY_W-1:0]] == tag) begin
        hit     = 1'b1;
        hit_way = w[WAY_W-1:0];
      end
      if (!free_found && states[index][w[WAY_W-1:0]] == MESI_I) begin
        free_found = 1'b1;
        free_way   = w[WAY_W-1:0];
      end
    end
    victim = free_found ? free_way : ptr[index];
  end

  // MESI transition for the matched line under the requested event.
  always_comb begin
    cur_state = states[index][hit_way];
    nxt_state = cur_state;
    case (ev_t'(mesi_cmd))
      EV_CPU_RD:  if (cur_state == MESI_I) nxt_state = (snoop_result == 2'b00) ? MESI_E : MESI_S;
      EV_CPU_WR:  nxt_state = MESI_M;
      EV_SNP_RD:  if (cur_state != MESI_I) nxt_state = MESI_S;
      EV_SNP_RFO: nxt_state = MESI_I;
      default:    nxt_state = cur_state;
    endcase
    ptr_next = (way == WAY_W'(WAYS - 1)) ? '0 : way + 3'd1;
  end

  // Tag storage needs no reset: a line is only meaningful while its state is non-I.
  always_ff @(posedge clk) begin
    if (rst_n && op_valid && op == OP_WRITE) tags[index][way] <= tag;
  end

  // State, replacement pointers and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        ptr[s[INDEX_W-1:0]] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) states[s[INDEX_W-1:0]][w[WAY_W-1:0]] <= MESI_I;
      end
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      rsp_mesi  <= MESI_I;
      result    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (op_valid && op != OP_NOP) begin
        rsp_valid <= 1'b1;
        case (op_t'(op))
          OP_WRITE: begin
            states[index][way] <= MESI_E;
            ptr[index]         <= ptr_next;
            rsp_hit            <= 1'b1;
            rsp_way            <= way;
            rsp_mesi           <= MESI_E;
            result             <= {way, 1'b1};
          end
          OP_SET_MESI: begin
            if (hit) states[index][hit_way] <= nxt_state;
            rsp_hit  <= hit;
            rsp_way  <= hit ? hit_way : victim;
            rsp_mesi <= hit ? nxt_state : MESI_I;
            result   <= {hit ? hit_way : victim, hit};
          end
          default: begin
            rsp_hit  <= hit;
            rsp_way  <= hit ? hit_way : victim;
            rsp_mesi <= hit ? cur_state : MESI_I;
            result   <= {hit ? hit_way : victim, hit};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cache_module.sv
// Self-checking bench for cache_module: directed scenarios plus random
// commands against an array-based directory model.
module tb_cache_module;

  localparam int INDEX_W = 4;
  localparam int TAG_W   = 12;
  localparam int WAYS    = 8;
  localparam int SETS    = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               op_valid = 1'b0;
  logic [1:0]         op = '0;
  logic [INDEX_W-1:0] index = '0;
  logic [TAG_W-1:0]   tag = '0;
  logic [2:0]         way = '0;
  logic [1:0]         mesi_cmd = '0;
  logic [1:0]         snoop_result = '0;
  logic               rsp_valid;
  logic               rsp_hit;
  logic [2:0]         rsp_way;
  logic [1:0]         rsp_mesi;
  logic [3:0]         result;

  cache_module #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .WAYS(WAYS), .OFFSET_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .index(index), .tag(tag),
    .way(way), .mesi_cmd(mesi_cmd), .snoop_result(snoop_result), .rsp_valid(rsp_valid),
    .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_mesi(rsp_mesi), .result(result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: state encoding I=0 S=1 E=2 M=3
  int m_tag [SETS][WAYS];
  int m_st  [SETS][WAYS];
  int m_ptr [SETS];
  int e_hit, e_way, e_mesi;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_st[s][w]  = 0;
        m_tag[s][w] = 0;
      end
    end
    e_hit = 0; e_way = 0; e_mesi = 0;
  endtask

  task automatic check_rsp(input string name, input int exp_valid);
    check({name, "_valid"}, 32'(rsp_valid), 32'(exp_valid));
    check({name, "_hit"},   32'(rsp_hit),   32'(e_hit));
    check({name, "_way"},   32'(rsp_way),   32'(e_way));
    check({name, "_mesi"},  32'(rsp_mesi),  32'(e_mesi));
    check({name, "_result"}, 32'(result),   32'(e_way * 2 + e_hit));
  endtask

  // Issue one command (or an idle cycle), update the model, check the response.
  task automatic cmd(input string name, input int v, input int o, input int idx, input int tg,
                     input int w, input int ev, input int snp);
    int hw, vic, st;
    hw = -1;
    vic = -1;
    for (int i = 0; i < WAYS; i++) begin
      if (hw < 0 && m_st[idx][i] != 0 && m_tag[idx][i] == tg) hw = i;
      if (vic < 0 && m_st[idx][i] == 0) vic = i;
    end
    if (vic < 0) vic = m_ptr[idx];
    if (v != 0 && o == 1) begin
      m_tag[idx][w] = tg;
      m_st[idx][w]  = 2;
      m_ptr[idx]    = (w + 1) % WAYS;
      e_hit = 1; e_way = w; e_mesi = 2;
    end else if (v != 0 && (o == 2 || o == 3)) begin
      if (hw >= 0) begin
        st = m_st[idx][hw];
        if (o == 2) begin
          case (ev)
            0: if (st == 0) st = (snp == 0) ? 2 : 1;
            1: st = 3;
            2: if (st != 0) st = 1;
            default: st = 0;
          endcase
          m_st[idx][hw] = st;
        end
        e_hit = 1; e_way = hw; e_mesi = st;
      end else begin
        e_hit = 0; e_way = vic; e_mesi = 0;
      end
    end
    op_valid     = v[0];
    op           = o[1:0];
    index        = idx[INDEX_W-1:0];
    tag          = tg[TAG_W-1:0];
    way          = w[2:0];
    mesi_cmd     = ev[1:0];
    snoop_result = snp[1:0];
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    index    = 4'($urandom);
    tag      = 12'($urandom);
    way      = 3'($urandom);
    check_rsp(name, (v != 0 && o != 0) ? 1 : 0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_rsp("reset", 0);
    rst_n = 1'b1;

    // 1: empty directory
    cmd("t1_check", 1, 3, 0, 'h111, 5, 0, 0);

    // 2: install, CPU write, check
    cmd("t2_write", 1, 1, 0, 'h111, 2, 0, 0);
    cmd("t2_cpu_wr", 1, 2, 0, 'h111, 7, 1, 0);
    cmd("t2_check", 1, 3, 0, 'h111, 0, 0, 0);
    cmd("t2_idle", 0, 3, 0, 'h111, 0, 0, 0);

    // 3: misses on other tag / other set
    cmd("t3_other_tag", 1, 3, 0, 'h222, 0, 0, 0);
    cmd("t3_other_set", 1, 3, 1, 'h111, 0, 0, 0);

    // 4: MESI walk on set 3 way 5
    cmd("t4_write", 1, 1, 3, 'hABC, 5, 0, 0);
    cmd("t4_snp_rd", 1, 2, 3, 'hABC, 0, 2, 0);
    cmd("t4_chk_s", 1, 3, 3, 'hABC, 0, 0, 0);
    cmd("t4_cpu_wr", 1, 2, 3, 'hABC, 0, 1, 0);
    cmd("t4_chk_m", 1, 3, 3, 'hABC, 0, 0, 0);
    cmd("t4_rfo", 1, 2, 3, 'hABC, 0, 3, 1);
    cmd("t4_chk_i", 1, 3, 3, 'hABC, 0, 0, 0);
    cmd("t4_rd_miss", 1, 2, 3, 'hABC, 0, 0, 0);
    cmd("t4_chk_i2", 1, 3, 3, 'hABC, 0, 0, 0);
    cmd("t4_nop", 1, 0, 3, 'hABC, 0, 0, 0);

    // 5: full set, pointer victim, then freed way victim
    for (int w = 0; w < WAYS; w++) cmd("t5_fill", 1, 1, 7, 'h700 + w, w, 0, 0);
    cmd("t5_full_miss", 1, 3, 7, 'h7FF, 3, 0, 0);
    cmd("t5_rfo4", 1, 2, 7, 'h704, 0, 3, 2);
    cmd("t5_free_miss", 1, 3, 7, 'h7FF, 0, 0, 0);
    cmd("t5_cpu_rd_hm", 1, 2, 7, 'h701, 0, 0, 3);

    // 6: reset wins over a simultaneous WRITE
    op_valid = 1'b1; op = 2'b01; index = 4'd2; tag = 12'h333; way = 3'd1; rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    op_valid = 1'b0;
    rst_n = 1'b1;
    check_rsp("t6_reset", 0);
    cmd("t6_check", 1, 3, 2, 'h333, 0, 0, 0);
    cmd("t6_old_line", 1, 3, 0, 'h111, 0, 0, 0);

    // Random traffic over a few sets and a small tag pool
    for (int n = 0; n < 500; n++) begin
      cmd("rand", ($urandom_range(0, 7) != 0) ? 1 : 0, $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 7),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
